// File: rtl/mmu_mem_responder_pkg.sv
// Shared types for the MMU-side memory responder: FSM state encoding and
// the width of the per-access latency counter.
package MemRespPkg;
    typedef enum logic [2:0] {
        IDLE,
        BUSY_D,
        BUSY_I,
        DONE_D,
        DONE_I
    } state_e;

    // Wide enough for LATENCY up to 15.
    localparam int LAT_CNT_W = 4;
endpackage

// File: rtl/mmu_mem_responder_array.sv
// Word storage for the responder. It has one synchronous byte-masked write
// port and one combinational read port. There is no reset, so the contents
// survive rstn.
module mem_resp_array #(
    parameter  int DATA_WIDTH = 64,
    parameter  int MEM_DEPTH  = 4096,
    localparam int IDX_W      = $clog2(MEM_DEPTH)
) (
    input  logic                    clk,
    input  logic                    we_i,
    input  logic [IDX_W-1:0]        waddr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    input  logic [DATA_WIDTH/8-1:0] wmask_i,
    input  logic [IDX_W-1:0]        raddr_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (wmask_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mmu_mem_responder.sv
// Fixed-latency memory responder serving the MMU's fetch and data ports.
// Data requests take priority over fetches. Define MEM_RESP_PERF_CNT_EN to
// build the cnt_i/cnt_d transaction counters; without it they read as zero.
module mmu_mem_responder
    import MemRespPkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int LATENCY    = 2,
    parameter int MEM_DEPTH  = 4096
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    if_mmu,
    input  logic [ADDR_WIDTH-1:0]   pc_phy,
    input  logic                    ren_mmu,
    input  logic                    wen_mmu,
    input  logic [ADDR_WIDTH-1:0]   addr_phy,
    input  logic [DATA_WIDTH-1:0]   wdata_mmu,
    input  logic [DATA_WIDTH/8-1:0] wmask_mmu,
    output logic                    if_stall,
    output logic                    mem_stall,
    output logic [31:0]             inst,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [31:0]             cnt_i,
    output logic [31:0]             cnt_d
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    state_e                  state_q, state_d;
    logic [LAT_CNT_W-1:0]    lat_q, lat_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    half_q, half_d;
    logic                    wr_q, wr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wmask_q, wmask_d;
    logic [DATA_WIDTH-1:0]   rdata_q, arr_rdata;
    logic [31:0]             inst_q;
    logic                    data_req, done_d_ent, done_i_ent, mem_we;
    logic                    unused_addr_bits;

    assign data_req  = ren_mmu | wen_mmu;
    assign mem_stall = data_req & (state_q != DONE_D);
    assign if_stall  = if_mmu   & (state_q != DONE_I);
    // Only the word index and the half-word select of either address are used.
    assign unused_addr_bits = ^{addr_phy, pc_phy};

    always_comb begin
        state_d    = state_q;
        lat_d      = lat_q;
        idx_d      = idx_q;
        half_d     = half_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        done_d_ent = 1'b0;
        done_i_ent = 1'b0;
        case (state_q)
            IDLE: begin
                if (data_req) begin
                    state_d = BUSY_D;
                    lat_d   = '0;
                    idx_d   = addr_phy[3 +: IDX_W];
                    half_d  = addr_phy[2];
                    wr_d    = wen_mmu;     // ren and wen both high acts as a write
                    wdata_d = wdata_mmu;
                    wmask_d = wmask_mmu;
                end else if (if_mmu) begin
                    state_d = BUSY_I;
                    lat_d   = '0;
                    idx_d   = pc_phy[3 +: IDX_W];
                    half_d  = pc_phy[2];
                    wr_d    = 1'b0;
                end
            end
            BUSY_D: begin
                if (!data_req) begin
                    state_d = IDLE;
                end else if (lat_q == LAT_CNT_W'(LATENCY-1)) begin
                    state_d    = DONE_D;
                    done_d_ent = 1'b1;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            BUSY_I: begin
                if (!if_mmu) begin
                    state_d = IDLE;
                end else if (lat_q == LAT_CNT_W'(LATENCY-1)) begin
                    state_d    = DONE_I;
                    done_i_ent = 1'b1;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset suppresses the commit of a write that would otherwise land this edge.
    assign mem_we = done_d_ent & wr_q & rstn;

    mem_resp_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_array (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (idx_q),
        .wdata_i (wdata_q),
        .wmask_i (wmask_q),
        .raddr_i (idx_q),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            lat_q   <= '0;
            rdata_q <= '0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            if (done_d_ent && !wr_q) rdata_q <= arr_rdata;
            if (done_i_ent) inst_q <= half_q ? arr_rdata[32 +: 32] : arr_rdata[31:0];
        end
    end

    always_ff @(posedge clk) begin
        idx_q   <= idx_d;
        half_q  <= half_d;
        wr_q    <= wr_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    assign rdata = rdata_q;
    assign inst  = inst_q;

`ifdef MEM_RESP_PERF_CNT_EN
    logic [31:0] cnt_i_q, cnt_d_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_i_q <= '0;
            cnt_d_q <= '0;
        end else begin
            if (done_i_ent) cnt_i_q <= cnt_i_q + 32'd1;
            if (done_d_ent) cnt_d_q <= cnt_d_q + 32'd1;
        end
    end

    assign cnt_i = cnt_i_q;
    assign cnt_d = cnt_d_q;
`else
    assign cnt_i = '0;
    assign cnt_d = '0;
`endif
endmodule

// File: doc/mmu_mem_responder.md
MMU_MEM_RESPONDER -- requirements
Module: mmu_mem_responder

Interface
REQ-001 Parameter ADDR_WIDTH, default 64, physical address width.
REQ-002 Parameter DATA_WIDTH, default 64, data word width; wmask width is DATA_WIDTH/8.
REQ-003 Parameter LATENCY, default 2, busy cycles per access; legal range 1..15.
REQ-004 Parameter MEM_DEPTH, default 4096, number of DATA_WIDTH words in storage; power of two.
REQ-005 clk  input  1  clock; reset rstn, synchronous, active-low; clock clk.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 if_mmu  input  1  instruction fetch request, level, held until if_stall low.
REQ-008 pc_phy  input  ADDR_WIDTH  fetch physical address.
REQ-009 ren_mmu / wen_mmu  input  1 each  data read / write request, level, held until mem_stall low.
REQ-010 addr_phy  input  ADDR_WIDTH  data physical address.
REQ-011 wdata_mmu  input  DATA_WIDTH  write data; wmask_mmu  input  DATA_WIDTH/8  byte enables.
REQ-012 if_stall  output  1  fetch not complete; mem_stall  output  1  data access not complete.
REQ-013 inst  output  32  fetched instruction; rdata  output  DATA_WIDTH  read data.
REQ-014 cnt_i / cnt_d  output  32 each  completed fetch / data transaction counters.

Function
REQ-015 FSM states: IDLE, BUSY_D, BUSY_I, DONE_D, DONE_I.
REQ-016 IDLE: data request (ren_mmu|wen_mmu) -> BUSY_D; else if_mmu -> BUSY_I; data wins simultaneous requests; latch address, wdata, wmask, op.
REQ-017 BUSY_x: latency counter increments each cycle; at count LATENCY-1 -> DONE_x; counter cleared on entry.
REQ-018 DONE_x -> IDLE unconditionally after one cycle; no new request accepted in DONE.
REQ-019 mem_stall = (ren_mmu|wen_mmu) & ~(state==DONE_D), combinational; if_stall = if_mmu & ~(state==DONE_I).
REQ-020 Stall asserts in the same cycle a request appears; a request is held for exactly LATENCY+2 cycles when uncontended.
REQ-021 Word index = address[3 +: log2(MEM_DEPTH)]; upper bits ignored (wrap-around); low 3 bits ignored for data.
REQ-022 Read: rdata registered on the BUSY_D->DONE_D edge, valid during DONE_D, held until next data read completes.
REQ-023 Write: byte-masked merge committed on the BUSY_D->DONE_D edge only; rdata unchanged by writes.
REQ-024 Fetch: inst = selected 32-bit half (pc_phy[2]=1 -> upper) registered on BUSY_I->DONE_I edge.
REQ-025 ren_mmu and wen_mmu both high: treated as write.
REQ-026 Request withdrawn during BUSY_x (e.g. flush): return to IDLE next cycle, no write commit, no counter increment, outputs unchanged.
REQ-027 Fetch pending during data service: if_stall stays high; fetch served starting the cycle after DONE_D.
REQ-028 Counters increment by 1 on each DONE_x entry; wrap at 2^32.

Reset
REQ-029 rstn low at a clock edge: state IDLE, counter 0, rdata 0, inst 0, cnt_i 0, cnt_d 0.
REQ-030 Reset mid-operation aborts the access; no write commit; storage contents not cleared.
REQ-031 Stall outputs follow REQ-019 during reset (combinational on requests and state).

Configuration
REQ-032 Macro MEM_RESP_PERF_CNT_EN defined: cnt_i/cnt_d implemented per REQ-028.
REQ-033 Macro undefined: cnt_i/cnt_d tied to 0, no counter flops; ports still present.

Structure
REQ-034 Package MemRespPkg holds state enum type and latency counter width constant.
REQ-035 Sub-module mem_resp_array: MEM_DEPTH x DATA_WIDTH storage, one synchronous byte-masked write port, one combinational read port.

Verification (LATENCY=2)
REQ-036 Write 0xDEAD_BEEF_0000_1111 mask 0xFF to 0x100, then read 0x100 -> mem_stall high 3 cycles, low in 4th; rdata=0xDEAD_BEEF_0000_1111.
REQ-037 Write 0xAA..AA mask 0x0F over 0x100 -> read returns 0xDEAD_BEEF_AAAA_AAAA.
REQ-038 if_mmu and ren_mmu raised same cycle -> DONE_D at cycle 3, DONE_I at cycle 7; if_stall high through cycle 6.
REQ-039 Fetch pc_phy 0x104 after REQ-036 -> inst=0xDEAD_BEEF.
REQ-040 wen_mmu dropped in BUSY_D -> IDLE next cycle, storage unchanged, cnt_d unchanged.
REQ-041 Address 0x8000 with MEM_DEPTH 4096 aliases index 0; rstn low mid-BUSY_I -> IDLE, inst=0, cnt_i=0.
